decode_ctrl_pipe: RTL and testbench

Registered, stall-aware successor to the combinational instruction decoder. It sits between fetch and the register file / execute stage. It accepts one 32-bit instruction per handshake and emits a one-cycle-latency registered control word. It also generates interlocks: a load-use bubble, multi-cycle MUL occupancy, and a JMP redirect slot. The opcode group offset and MUL latency are parameters, so one RTL source serves every group build.

---
 rtl/decode_ctrl_pipe_if.sv | 22 ++
 rtl/decode_ctrl_pipe.sv | 170 +++++++++++++++++
 tb/tb_decode_ctrl_pipe.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_ctrl_pipe_if.sv
// Handshake and control-word bundle between fetch/execute and decode_ctrl_pipe.
// The master side drives the instruction stream and flush; the slave side is the decoder.
interface decode_ctrl_pipe_if;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instruction;
  logic        ctrl_valid;
  logic [31:0] ctrl;
  logic        jmp_flag;
  logic [31:0] jmp_address;

  modport master (
    output flush, in_valid, instruction,
    input  in_ready, ctrl_valid, ctrl, jmp_flag, jmp_address
  );

  modport slave (
    input  flush, in_valid, instruction,
    output in_ready, ctrl_valid, ctrl, jmp_flag, jmp_address
  );
endinterface

// File: rtl/decode_ctrl_pipe.sv
// Registered instruction decoder with load-use, MUL-occupancy and JMP-slot interlocks.
// One instruction per handshake; the control word appears one cycle after acceptance.
module decode_ctrl_pipe #(
  parameter int GROUP      = 15,
  parameter int MUL_CYCLES = 3,
  parameter int HAZARD_EN  = 1
) (
  input  logic             clk,
  input  logic             rst,
  decode_ctrl_pipe_if.slave bus
);

  localparam logic [5:0] OP_LW   = 6'(GROUP + 32);
  localparam logic [5:0] OP_SW   = 6'(GROUP + 33);
  localparam logic [5:0] OP_BNE  = 6'(GROUP + 34);
  localparam logic [5:0] OP_R    = 6'(GROUP + 10);
  localparam logic [5:0] OP_JMP  = 6'd2;
  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);
  localparam bit         HZ_ON    = (HAZARD_EN != 0);

  logic [31:0] r_ctrl;
  logic        r_ctrl_valid;
  logic        r_jmp_flag;
  logic [31:0] r_jmp_address;
  logic [3:0]  r_mul_cnt;
  logic        r_lw_pend;
  logic [4:0]  r_lw_rd;
  logic        r_jmp_slot;

  logic [5:0]  w_op;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [5:0]  w_funct;
  logic        w_is_lw;
  logic        w_is_jmp;
  logic        w_is_mul;
  logic        w_uses_rt;
  logic        w_lu_hazard;
  logic        w_ready;
  logic        w_accept;

  logic [4:0]  w_dec_rs;
  logic [4:0]  w_dec_rt;
  logic [4:0]  w_dec_rd;
  logic [1:0]  w_alu_op;
  logic        w_we_dm;
  logic        w_we_rf;
  logic        w_sel_mux3;
  logic        w_sel_mux2;
  logic        w_sel_mux5;
  logic        w_branch;
  logic [31:0] w_ctrl_word;

  assign w_op    = bus.instruction[31:26];
  assign w_rs    = bus.instruction[25:21];
  assign w_rt    = bus.instruction[20:16];
  assign w_rd    = bus.instruction[15:11];
  assign w_funct = bus.instruction[5:0];

  assign w_is_lw   = (w_op == OP_LW);
  assign w_is_jmp  = (w_op == OP_JMP);
  assign w_is_mul  = (w_op == OP_R) && (w_funct == 6'd50);
  assign w_uses_rt = (w_op == OP_R) || (w_op == OP_SW) || (w_op == OP_BNE);

  // Hazard uses raw register fields so in_ready never waits on decoded outputs.
  assign w_lu_hazard = HZ_ON && r_lw_pend && (r_lw_rd != 5'd0) && bus.in_valid &&
                       ((w_rs == r_lw_rd) || (w_uses_rt && (w_rt == r_lw_rd)));

  assign w_ready  = !rst && !bus.flush && (r_mul_cnt == 4'd0) && !r_jmp_slot && !w_lu_hazard;
  assign w_accept = bus.in_valid && w_ready;

  always_comb begin
    w_dec_rs   = w_rs;
    w_dec_rt   = w_rt;
    w_dec_rd   = w_rd;
    w_alu_op   = 2'b00;
    w_we_dm    = 1'b0;
    w_we_rf    = 1'b0;
    w_sel_mux3 = 1'b0;
    w_sel_mux2 = 1'b0;
    w_sel_mux5 = 1'b0;
    w_branch   = 1'b0;
    case (w_op)
      OP_LW: begin
        w_dec_rd   = w_rt;
        w_sel_mux2 = 1'b1;
        w_sel_mux5 = 1'b1;
        w_we_rf    = 1'b1;
      end
      OP_SW: begin
        w_dec_rd   = 5'd0;
        w_sel_mux2 = 1'b1;
        w_sel_mux5 = 1'b1;
        w_we_dm    = 1'b1;
      end
      OP_BNE: begin
        w_dec_rd = 5'd0;
        w_branch = 1'b1;
        w_alu_op = 2'b01;
      end
      OP_R: begin
        w_we_rf = 1'b1;
        case (w_funct)
          6'd32: w_alu_op = 2'b00;
          6'd34: w_alu_op = 2'b01;
          6'd36: w_alu_op = 2'b10;
          6'd37: w_alu_op = 2'b11;
          6'd50: w_sel_mux3 = 1'b1;
          default: begin
            w_dec_rs = 5'd0;
            w_dec_rt = 5'd0;
            w_dec_rd = 5'd0;
            w_we_rf  = 1'b0;
          end
        endcase
      end
      default: begin
        w_dec_rs = 5'd0;
        w_dec_rt = 5'd0;
        w_dec_rd = 5'd0;
      end
    endcase
  end

  assign w_ctrl_word = {w_dec_rs, w_dec_rt, w_dec_rd, w_alu_op, w_we_dm, w_we_rf,
                        w_sel_mux3, w_sel_mux2, w_sel_mux5, w_branch, 9'd0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctrl        <= '0;
      r_ctrl_valid  <= 1'b0;
      r_jmp_flag    <= 1'b0;
      r_jmp_address <= '0;
      r_mul_cnt     <= '0;
      r_lw_pend     <= 1'b0;
      r_lw_rd       <= '0;
      r_jmp_slot    <= 1'b0;
    end else if (bus.flush) begin
      // jmp_address deliberately survives a flush
      r_ctrl       <= '0;
      r_ctrl_valid <= 1'b0;
      r_jmp_flag   <= 1'b0;
      r_mul_cnt    <= '0;
      r_lw_pend    <= 1'b0;
      r_jmp_slot   <= 1'b0;
    end else begin
      r_ctrl_valid <= w_accept && !w_is_jmp;
      r_ctrl       <= (w_accept && !w_is_jmp) ? w_ctrl_word : '0;
      r_jmp_flag   <= w_accept && w_is_jmp;
      r_jmp_slot   <= w_accept && w_is_jmp;
      r_lw_pend    <= w_accept && w_is_lw;
      if (w_accept && w_is_jmp)
        r_jmp_address <= {6'd0, bus.instruction[25:0]};
      if (w_accept && w_is_lw)
        r_lw_rd <= w_rt;
      if (w_accept && w_is_mul)
        r_mul_cnt <= MUL_LOAD;
      else if (r_mul_cnt != 4'd0)
        r_mul_cnt <= r_mul_cnt - 4'd1;
    end
  end

  assign bus.in_ready    = w_ready;
  assign bus.ctrl        = r_ctrl;
  assign bus.ctrl_valid  = r_ctrl_valid;
  assign bus.jmp_flag    = r_jmp_flag;
  assign bus.jmp_address = r_jmp_address;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Bench for decode_ctrl_pipe: four parameter builds share one directed stream and are
// each checked every cycle against a cycle-indexed behavioural model, plus literal pins.
module tb_decode_ctrl_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] instruction = '0;
  logic        flush = 1'b0;

  int n_vec  = 0;
  int n_fail = 0;
  int n_tx   = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h", nm, act, exp);
    end
  endtask

  // Control word straight from the decode rules, assembled by shifting each field into place.
  function automatic logic [31:0] model_ctrl(input logic [31:0] ins, input int g);
    int op, rs, rt, rd, f, alu, dm, rf, m3, m2, m5, br;
    op = int'(ins[31:26]); rs = int'(ins[25:21]); rt = int'(ins[20:16]);
    rd = int'(ins[15:11]); f = int'(ins[5:0]);
    alu = 0; dm = 0; rf = 0; m3 = 0; m2 = 0; m5 = 0; br = 0;
    if (op == g + 32) begin
      rd = rt; m2 = 1; m5 = 1; rf = 1;
    end else if (op == g + 33) begin
      rd = 0; m2 = 1; m5 = 1; dm = 1;
    end else if (op == g + 34) begin
      rd = 0; br = 1; alu = 1;
    end else if (op == g + 10) begin
      rf = 1;
      if (f == 34) alu = 1;
      else if (f == 36) alu = 2;
      else if (f == 37) alu = 3;
      else if (f == 50) m3 = 1;
      else if (f != 32) begin rs = 0; rt = 0; rd = 0; rf = 0; end
    end else begin
      rs = 0; rt = 0; rd = 0;
    end
    return (32'(rs) << 27) | (32'(rt) << 22) | (32'(rd) << 17) | (32'(alu) << 15) |
           (32'(dm) << 14) | (32'(rf) << 13) | (32'(m3) << 12) | (32'(m2) << 11) |
           (32'(m5) << 10) | (32'(br) << 9);
  endfunction

  function automatic bit model_uses_rt(input logic [31:0] ins, input int g);
    int op;
    op = int'(ins[31:26]);
    return (op == g + 10) || (op == g + 33) || (op == g + 34);
  endfunction

  function automatic logic [31:0] rt_ins(input int rs, input int rt, input int rd, input int f);
    return {6'd25, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(f)};
  endfunction

  function automatic logic [31:0] it_ins(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  // u0: defaults, u1: HAZARD_EN=0, u2: MUL_CYCLES=1, u3: GROUP=0
  for (genvar gi = 0; gi < 4; gi++) begin : g_inst
    localparam int G  = (gi == 3) ? 0 : 15;
    localparam int MC = (gi == 2) ? 1 : 3;
    localparam int HE = (gi == 1) ? 0 : 1;

    decode_ctrl_pipe_if dif ();
    assign dif.in_valid    = in_valid;
    assign dif.instruction = instruction;
    assign dif.flush       = flush;

    decode_ctrl_pipe #(.GROUP(G), .MUL_CYCLES(MC), .HAZARD_EN(HE)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (dif)
    );

    // Model time base: cycle k lies between clock edges k and k+1.
    int          cyc   = 0;
    int          mfree = 0;
    int          jblk  = -1;
    int          lwc   = -10;
    logic [4:0]  lwrd  = '0;
    logic [31:0] e_ctrl = '0;
    logic [31:0] e_ja   = '0;
    logic        e_val  = 1'b0;
    logic        e_jf   = 1'b0;
    logic        m_haz, m_rdy, m_acc;
    int          m_op;

    always_comb begin
      m_op  = int'(instruction[31:26]);
      m_haz = (HE != 0) && (lwc == cyc - 1) && (lwrd != 5'd0) && in_valid &&
              ((instruction[25:21] == lwrd) ||
               (model_uses_rt(instruction, G) && (instruction[20:16] == lwrd)));
      m_rdy = !rst && !flush && (cyc >= mfree) && (cyc != jblk) && !m_haz;
      m_acc = in_valid && m_rdy;
    end

    always @(posedge clk or posedge rst) begin
      if (rst) begin
        mfree <= 0; jblk <= -1; lwc <= -10;
        e_ctrl <= '0; e_val <= 1'b0; e_jf <= 1'b0; e_ja <= '0;
      end else begin
        cyc <= cyc + 1;
        if (flush) begin
          mfree <= 0; jblk <= -1; lwc <= -10;
          e_ctrl <= '0; e_val <= 1'b0; e_jf <= 1'b0;
        end else begin
          e_val  <= m_acc && (m_op != 2);
          e_ctrl <= (m_acc && (m_op != 2)) ? model_ctrl(instruction, G) : '0;
          e_jf   <= m_acc && (m_op == 2);
          if (m_acc && (m_op == 2)) begin
            e_ja <= {6'd0, instruction[25:0]};
            jblk <= cyc + 1;
          end
          if (m_acc && (m_op == G + 32)) begin
            lwc  <= cyc;
            lwrd <= instruction[20:16];
          end
          if (m_acc && (m_op == G + 10) && (instruction[5:0] == 6'd50))
            mfree <= cyc + MC;
        end
      end
    end

    always @(negedge clk) begin
      chk($sformatf("u%0d.in_ready", gi), {31'd0, dif.in_ready}, {31'd0, m_rdy});
      chk($sformatf("u%0d.ctrl_valid", gi), {31'd0, dif.ctrl_valid}, {31'd0, e_val});
      chk($sformatf("u%0d.ctrl", gi), dif.ctrl, e_ctrl);
      chk($sformatf("u%0d.jmp_flag", gi), {31'd0, dif.jmp_flag}, {31'd0, e_jf});
      chk($sformatf("u%0d.jmp_address", gi), dif.jmp_address, e_ja);
    end
  end

  task automatic drive(input logic v, input logic [31:0] ins, input logic fl);
    @(posedge clk);
    #1;
    in_valid = v; instruction = ins; flush = fl;
    n_tx++;
    $display("tx %0d: valid=%0b instr=%08h flush=%0b", n_tx, v, ins, fl);
    @(negedge clk);
    #1;
  endtask

  int sel, ra, rb, rc, fn;
  int fn_tab[6] = '{32, 34, 36, 37, 50, 7};
  logic [31:0] rins;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst.in_ready", {31'd0, g_inst[0].dif.in_ready}, 32'd0);
    chk("rst.ctrl_valid", {31'd0, g_inst[0].dif.ctrl_valid}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rel.in_ready", {31'd0, g_inst[0].dif.in_ready}, 32'd1);

    // ADD r3 = r1 + r2
    drive(1, rt_ins(1, 2, 3, 32), 0);
    chk("add.in_ready", {31'd0, g_inst[0].dif.in_ready}, 32'd1);
    drive(0, 32'd0, 0);
    chk("add.ctrl", g_inst[0].dif.ctrl, 32'h0886_2000);
    chk("add.ctrl_valid", {31'd0, g_inst[0].dif.ctrl_valid}, 32'd1);

    // LW r4 then dependent ADD
    drive(1, it_ins(47, 1, 4, 8), 0);
    drive(1, rt_ins(4, 5, 6, 32), 0);
    chk("lu.u0_ready", {31'd0, g_inst[0].dif.in_ready}, 32'd0);
    chk("lu.u1_ready_nohz", {31'd0, g_inst[1].dif.in_ready}, 32'd1);
    drive(1, rt_ins(4, 5, 6, 32), 0);
    chk("lu.u0_ready2", {31'd0, g_inst[0].dif.in_ready}, 32'd1);
    chk("lu.u0_bubble", {31'd0, g_inst[0].dif.ctrl_valid}, 32'd0);
    drive(0, 32'd0, 0);
    chk("lu.u0_add", g_inst[0].dif.ctrl, 32'h214C_2000);

    // LW r0 never interlocks
    drive(1, it_ins(47, 1, 0, 0), 0);
    drive(1, rt_ins(0, 2, 3, 32), 0);
    chk("lu0.ready", {31'd0, g_inst[0].dif.in_ready}, 32'd1);
    drive(0, 32'd0, 0);

    // MUL occupancy, back-to-back SUBs
    drive(1, rt_ins(1, 2, 7, 50), 0);
    drive(1, rt_ins(3, 4, 9, 34), 0);
    chk("mul.ready_c1", {31'd0, g_inst[0].dif.in_ready}, 32'd0);
    chk("mul.mc1_ready", {31'd0, g_inst[2].dif.in_ready}, 32'd1);
    chk("mul.ctrl", g_inst[0].dif.ctrl, 32'h088E_3000);
    drive(1, rt_ins(3, 4, 9, 34), 0);
    chk("mul.ready_c2", {31'd0, g_inst[0].dif.in_ready}, 32'd0);
    drive(1, rt_ins(3, 4, 9, 34), 0);
    chk("mul.ready_c3", {31'd0, g_inst[0].dif.in_ready}, 32'd1);
    drive(0, 32'd0, 0);
    chk("mul.sub_ctrl", g_inst[0].dif.ctrl, 32'h1912_A000);

    // JMP redirect slot
    drive(1, {6'd2, 26'h012_3456}, 0);
    drive(1, rt_ins(1, 2, 3, 36), 0);
    chk("jmp.ready", {31'd0, g_inst[0].dif.in_ready}, 32'd0);
    chk("jmp.flag", {31'd0, g_inst[0].dif.jmp_flag}, 32'd1);
    chk("jmp.addr", g_inst[0].dif.jmp_address, 32'h0012_3456);
    chk("jmp.ctrl_valid", {31'd0, g_inst[0].dif.ctrl_valid}, 32'd0);
    drive(1, rt_ins(1, 2, 3, 36), 0);
    chk("jmp.ready2", {31'd0, g_inst[0].dif.in_ready}, 32'd1);
    chk("jmp.flag_drop", {31'd0, g_inst[0].dif.jmp_flag}, 32'd0);
    drive(0, 32'd0, 0);

    // flush during MUL stall right after an LW
    drive(1, it_ins(47, 1, 7, 0), 0);
    drive(1, rt_ins(1, 2, 8, 50), 0);
    drive(1, rt_ins(3, 4, 5, 34), 1);
    chk("fl.ready_during", {31'd0, g_inst[0].dif.in_ready}, 32'd0);
    drive(1, rt_ins(3, 4, 5, 34), 0);
    chk("fl.ready_after", {31'd0, g_inst[0].dif.in_ready}, 32'd1);
    chk("fl.ctrl_valid", {31'd0, g_inst[0].dif.ctrl_valid}, 32'd0);
    chk("fl.jmp_addr_hold", g_inst[0].dif.jmp_address, 32'h0012_3456);
    drive(1, it_ins(47, 1, 9, 0), 0);
    drive(1, rt_ins(9, 1, 2, 32), 1);
    drive(1, rt_ins(9, 1, 2, 32), 0);
    chk("fl.lw_cleared", {31'd0, g_inst[0].dif.in_ready}, 32'd1);
    drive(0, 32'd0, 0);

    // reset in the middle of a MUL
    drive(1, rt_ins(1, 2, 3, 50), 0);
    drive(0, 32'd0, 0);
    rst = 1'b1;
    #1;
    chk("rstmid.ctrl_valid", {31'd0, g_inst[0].dif.ctrl_valid}, 32'd0);
    chk("rstmid.ctrl", g_inst[0].dif.ctrl, 32'd0);
    chk("rstmid.jmp_addr", g_inst[0].dif.jmp_address, 32'd0);
    chk("rstmid.in_ready", {31'd0, g_inst[0].dif.in_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rstmid.rel_ready", {31'd0, g_inst[0].dif.in_ready}, 32'd1);

    // GROUP=0 build: op 32 is LW, op 47 is an unknown NOP
    drive(1, it_ins(32, 1, 5, 0), 0);
    drive(1, it_ins(47, 2, 3, 0), 0);
    chk("g0.ready", {31'd0, g_inst[3].dif.in_ready}, 32'd1);
    chk("g0.lw_ctrl", g_inst[3].dif.ctrl, 32'h094A_2C00);
    drive(0, 32'd0, 0);
    chk("g0.nop_ctrl", g_inst[3].dif.ctrl, 32'd0);
    chk("g0.nop_valid", {31'd0, g_inst[3].dif.ctrl_valid}, 32'd1);

    // mixed stream, small register numbers so interlocks fire often
    for (int k = 0; k < 80; k++) begin
      sel = $urandom_range(0, 8);
      ra = $urandom_range(0, 5); rb = $urandom_range(0, 5); rc = $urandom_range(0, 5);
      fn = fn_tab[$urandom_range(0, 5)];
      case (sel)
        0, 1, 2: rins = rt_ins(ra, rb, rc, fn);
        3:       rins = it_ins(47, ra, rb, k);
        4:       rins = it_ins(48, ra, rb, k);
        5:       rins = it_ins(49, ra, rb, k);
        6:       rins = {6'd2, 26'($urandom)};
        7:       rins = it_ins(32, ra, rb, k);
        default: rins = it_ins(30, ra, rb, k);
      endcase
      drive(($urandom_range(0, 3) != 0), rins, ($urandom_range(0, 11) == 0));
    end
    repeat (3) drive(0, 32'd0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
